// File: rtl/seq_mul_arbiter.sv
// seq_mul_arbiter: round-robin sharing of one sequential multiplier among NUM_REQ clients.
// One job in flight; a watchdog aborts jobs whose multiplier never signals done.
module seq_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [2*WIDTH-1:0]       rsp_prod_o,
  output logic                     rsp_err_o,
  output logic                     busy_o,
  output logic                     mul_start_o,
  output logic [WIDTH-1:0]         mul_a_o,
  output logic [WIDTH-1:0]         mul_b_o,
  input  logic                     mul_done_i,
  input  logic [2*WIDTH-1:0]       mul_prod_i
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESPOND} state_t;
  state_t          state_q;
  logic [PW-1:0]   ptr_q, owner_q, win_d, idx;
  logic [CW-1:0]   wd_q;
  // Scan downwards so the lowest offset from ptr_q is written last and wins.
  always_comb begin
    win_d = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_i[idx]) win_d = idx;
    end
  end
  assign busy_o = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      wd_q        <= '0;
      gnt_o       <= '0;
      rsp_valid_o <= '0;
      rsp_prod_o  <= '0;
      rsp_err_o   <= 1'b0;
      mul_start_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
    end else begin
      gnt_o       <= '0;
      mul_start_o <= 1'b0;
      rsp_valid_o <= '0;
      rsp_prod_o  <= '0;
      rsp_err_o   <= 1'b0;
      case (state_q)
        IDLE: if (|req_i) begin
          owner_q     <= win_d;
          mul_a_o     <= WIDTH'(req_a_i >> (int'(win_d) * WIDTH));
          mul_b_o     <= WIDTH'(req_b_i >> (int'(win_d) * WIDTH));
          gnt_o       <= NUM_REQ'(1) << win_d;
          mul_start_o <= 1'b1;
          state_q     <= LAUNCH;
        end
        LAUNCH: begin
          ptr_q   <= (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
          wd_q    <= '0;
          state_q <= BUSY;
        end
        BUSY: if (mul_done_i) begin
          rsp_valid_o <= NUM_REQ'(1) << owner_q;
          rsp_prod_o  <= mul_prod_i;
          state_q     <= RESPOND;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          rsp_valid_o <= NUM_REQ'(1) << owner_q;
          rsp_err_o   <= 1'b1;
          state_q     <= RESPOND;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
